// File: rtl/reg_dump_reader.sv
// rtl/reg_dump_reader.sv - streams register file 0..NUM_REGS-1 over valid/ready; optional XOR checksum word via REG_DUMP_CHECKSUM_EN
module reg_dump_reader #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W:0]   out_index,
    output logic              out_last,
    output logic              busy,
    output logic              done
);
    localparam int IW = ADDR_W + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
`ifdef REG_DUMP_CHECKSUM_EN
        CSUM,
`endif
        DONE
    } state_t;

    state_t        state;
    logic [IW-1:0] rd_ptr;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] csum;
`endif

    // rd_ptr reaches NUM_REGS after the last load; the wrapped read is never used
    assign rf_raddr = rd_ptr[ADDR_W-1:0];
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
`ifdef REG_DUMP_CHECKSUM_EN
    assign out_last = (state == CSUM);
`else
    assign out_last = (state == SEND) && (out_index == LAST_IDX);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rd_ptr    <= '0;
            out_data  <= '0;
            out_index <= '0;
            out_valid <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            csum      <= '0;
`endif
        end else if (abort) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rd_ptr <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
                        csum   <= '0;
`endif
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    out_data  <= rf_rdata;
                    out_index <= rd_ptr;
                    out_valid <= 1'b1;
                    rd_ptr    <= rd_ptr + IW'(1);
                    state     <= SEND;
                end
                SEND: begin
                    // out_valid is always high here, so out_ready alone is the handshake
                    if (out_ready) begin
`ifdef REG_DUMP_CHECKSUM_EN
                        csum <= csum ^ out_data;
`endif
                        if (out_index < LAST_IDX) begin
                            out_data  <= rf_rdata;
                            out_index <= rd_ptr;
                            rd_ptr    <= rd_ptr + IW'(1);
                        end else begin
`ifdef REG_DUMP_CHECKSUM_EN
                            out_data  <= csum ^ out_data;
                            out_index <= IW'(NUM_REGS);
                            state     <= CSUM;
`else
                            out_valid <= 1'b0;
                            state     <= DONE;
`endif
                        end
                    end
                end
`ifdef REG_DUMP_CHECKSUM_EN
                CSUM: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= DONE;
                    end
                end
`endif
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/reg_dump_reader.md
# reg_dump_reader

Debug read-out engine for the CPU register file. When started, it walks a register-file read port from register 0 to register NUM_REGS-1 and streams each word to a consumer over a valid/ready handshake. The consumer is a debug/trace or UART bridge. The block shares a read address with the register file's combinational read path, and asserts `busy` so the core can stall while a coherent snapshot is taken.

## Interface
Parameters:
- `NUM_REGS`, 32: number of registers dumped, indices 0..NUM_REGS-1.
- `ADDR_W`, 5: register-file address width; NUM_REGS ≤ 2^ADDR_W.
- `DATA_W`, 32: register data width.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a dump; sampled only in IDLE, ignored otherwise.
- `abort`  in  1  synchronous cancel; returns to IDLE from any state, no `done`.
- `rf_raddr`  out  ADDR_W  read address driven to the register file; equals `rd_ptr[ADDR_W-1:0]`.
- `rf_rdata`  in  DATA_W  combinational read data for `rf_raddr`, valid in the same cycle.
- `out_valid`  out  1  `out_data`, `out_index` and `out_last` are valid.
- `out_ready`  in  1  consumer accepts the word when `out_valid && out_ready`.
- `out_data`  out  DATA_W  current word.
- `out_index`  out  ADDR_W+1  register index of the word; NUM_REGS for the checksum word.
- `out_last`  out  1  marks the final word of the dump.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the final word is accepted.

## Operation
- State machine states: IDLE, LOAD, SEND, CSUM, DONE.
- Registers: `rd_ptr` (ADDR_W+1 bits), `out_data`, `out_index`, `out_valid`, `csum` (DATA_W bits).
- Reset values: state IDLE; `rd_ptr`, `out_data`, `out_index` and `csum` all 0; `out_valid`, `out_last`, `busy` and `done` all 0.
- IDLE:
  - On `start` (and no `abort`): `rd_ptr`←0, `csum`←0, go to LOAD.
- LOAD (exactly 1 cycle):
  - `out_data`←`rf_rdata`, `out_index`←`rd_ptr`, `out_valid`←1, `rd_ptr`←`rd_ptr`+1.
  - Go to SEND.
- SEND:
  - Without a handshake, all outputs hold stable.
  - On a handshake, `csum`←`csum`^`out_data`.
  - On a handshake with `out_index`<NUM_REGS-1: load the next word exactly as LOAD does and stay in SEND. `out_valid` stays 1, giving back-to-back words at 1 word/cycle.
  - On a handshake with `out_index`==NUM_REGS-1: go to DONE with `out_valid`←0. With the checksum macro defined, go to CSUM instead (see Configuration).
- CSUM:
  - Hold the checksum word until the handshake, then go to DONE with `out_valid`←0.
- DONE:
  - `done`=1 for this one cycle, then go to IDLE.
- `out_last` is combinational: high in SEND when `out_index`==NUM_REGS-1 and the checksum is compiled out; high in CSUM.
- `abort` has priority over every transition: next state IDLE, `out_valid`←0, `rd_ptr` and `csum` unchanged (don't-care), no `done` pulse.
- `start` asserted during a dump, or coincident with `done`, is ignored (not queued).
- Each word is the register value in the cycle it was loaded. Writes to a not-yet-loaded register during the dump appear in the stream; writes to already-loaded registers do not.
- `rd_ptr` never exceeds NUM_REGS. When it equals NUM_REGS, `rf_raddr` wraps to 0; that read is harmless because the data is never used.

## Timing
- Start latency: `start` sampled in cycle T → LOAD in T+1 → first word (`out_index`=0) valid in T+2.
- With `out_ready` held high:
  - word i is accepted in cycle T+2+i;
  - without checksum: `done` in T+2+NUM_REGS, IDLE in T+3+NUM_REGS;
  - with checksum: checksum word in T+2+NUM_REGS, `done` in T+3+NUM_REGS.
- `busy` rises in T+1 and falls the cycle after `done`.
- A new `start` is accepted in the first IDLE cycle.
- Backpressure adds exactly one cycle per cycle of `out_ready` low. Data never changes while `out_valid && !out_ready`.
- `rf_raddr` changes only on clock edges (it is driven from a register).

## Configuration
- Macro: `REG_DUMP_CHECKSUM_EN`.
- Defined:
  - On acceptance of word NUM_REGS-1, load `out_data`←`csum`^(word NUM_REGS-1), `out_index`←NUM_REGS, keep `out_valid`=1, enter CSUM.
  - The stream is NUM_REGS+1 words, and `out_last` marks the checksum word.
- Not defined:
  - CSUM state and `csum` register are absent.
  - The stream is NUM_REGS words, and `out_last` marks word NUM_REGS-1.

## Test plan
- Async reset: pulse `reset` mid-dump between clock edges → all outputs 0 immediately, state IDLE; `start` afterwards begins a fresh dump at index 0.
- Full dump, `out_ready`=1, register file holds r[i]=i·0x01010101:
  - 32 words in consecutive cycles, `out_index` 0..31, `out_data`[0]=0, `out_data`[31]=0x1F1F1F1F, `out_last` on word 31;
  - `done` 34 cycles after `start`.
- Backpressure: toggle `out_ready` 1,0,0,1,… → `out_data`, `out_index` and `out_valid` stable while stalled; every index appears exactly once, in order.
- Abort: assert `abort` while `out_index`=10 → `out_valid`=0 and `busy`=0 next cycle, no `done`. The next `start` emits index 0 first.
- Start while busy: pulse `start` at index 5 → stream unaffected, exactly one `done`.
- With `REG_DUMP_CHECKSUM_EN`, r[i]=i: 33rd word has `out_index`=32, `out_data`=XOR of 0..31 = 0x00000000, `out_last`=1. With r[i]=1<<i the checksum word is 0xFFFFFFFF.
